// File: rtl/rr_arbiter_4req_pkg.sv
// ============================================================================
// Module  : rr_arbiter_4req_pkg
// Brief   : Shared FSM encodings and default parameters for the 4-way arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rr_arbiter_4req_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned C_DEF_N        = 4;
  localparam int unsigned C_DEF_MAX_HOLD = 8;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_4req_pick.sv
// ============================================================================
// Module  : rr_priority_pick
// Brief   : Combinational rotating priority pick; index ptr has top priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_priority_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         vec_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic [N-1:0]         onehot_o
);

  localparam int unsigned IDW = $clog2(N);

  logic [2*N-1:0] dbl_shift;
  logic [N-1:0]   rot;
  logic [IDW-1:0] enc;

  // Doubling the vector turns the rotate-right into a plain shift.
  assign dbl_shift = {vec_i, vec_i} >> ptr_i;
  assign rot       = dbl_shift[N-1:0];

  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc = IDW'(i);
      end
    end
  end

  assign any_o    = |vec_i;
  assign idx_o    = enc + ptr_i;
  assign onehot_o = any_o ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_4req.sv
// ============================================================================
// Module  : rr_arbiter_4req
// Brief   : Round-robin arbiter with owner hold, release and hold timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_4req
  import rr_arbiter_4req_pkg::*;
#(
  parameter int unsigned N        = C_DEF_N,
  parameter int unsigned IDW      = $clog2(N),
  parameter int unsigned MAX_HOLD = C_DEF_MAX_HOLD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_i,
  input  logic           done_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] grant_id_o,
  output logic           grant_valid_o,
  output logic           timeout_o
);

  localparam int unsigned HW = $clog2(MAX_HOLD);

  arb_state_e     state_q;
  logic [IDW-1:0] ptr_q;
  logic [HW-1:0]  hold_cnt_q;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] grant_id_q;
  logic           grant_valid_q;
  logic           timeout_q;

  logic           owner_req;
  logic           hold_hit;
  logic           release_now;
  logic [IDW-1:0] ptr_d;
  logic [N-1:0]   pick_vec;
  logic [IDW-1:0] pick_ptr;
  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_oh;

  assign owner_req   = |(req_i & grant_q);
  assign hold_hit    = (hold_cnt_q == HW'(MAX_HOLD - 1));
  assign release_now = done_i | ~owner_req | hold_hit;
  assign ptr_d       = grant_id_q + IDW'(1);

  // On a handoff the pick already uses the advanced pointer and excludes the owner.
  assign pick_vec = (state_q == ST_BUSY) ? (req_i & ~grant_q) : req_i;
  assign pick_ptr = (state_q == ST_BUSY) ? ptr_d : ptr_q;

  rr_priority_pick #(
    .N (N)
  ) u_pick (
    .vec_i    (pick_vec),
    .ptr_i    (pick_ptr),
    .any_o    (pick_any),
    .idx_o    (pick_idx),
    .onehot_o (pick_oh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q       <= pick_oh;
            grant_id_q    <= pick_idx;
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= '0;
            state_q       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (release_now) begin
            ptr_q      <= ptr_d;
            hold_cnt_q <= '0;
            timeout_q  <= hold_hit & ~done_i & owner_req;
            if (pick_any) begin
              grant_q    <= pick_oh;
              grant_id_q <= pick_idx;
            end else begin
              grant_q       <= '0;
              grant_id_q    <= '0;
              grant_valid_q <= 1'b0;
              state_q       <= ST_IDLE;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = grant_id_q;
  assign grant_valid_o = grant_valid_q;
  assign timeout_o     = timeout_q;

endmodule

`default_nettype wire
